// File: rtl/wb_select_arb.sv
// Write-back select arbiter: picks one of NUM_SRC valid/ready producers and registers
// its data/address into a single back-pressured register-file write port.
module wb_select_arb #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned CNT_WIDTH  = 8,
  localparam int unsigned SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          write_valid,
  input  logic                          write_ready,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic [SRC_W-1:0]              write_src,
  input  logic                          clear_count,
  output logic [CNT_WIDTH-1:0]          conflict_count
);

  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("wb_select_arb: NUM_SRC must be in 2..16");
  end
  if (ARB_MODE > 1) begin : g_bad_arb_mode
    $error("wb_select_arb: ARB_MODE must be 0 or 1");
  end

  logic                  accept;
  logic                  grant_found;
  logic [SRC_W-1:0]      grant_idx;
  logic                  transfer;
  logic                  contended;
  logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_SRC];

  // Unpack the flattened source buses so the mux indexes by grant directly
  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_unpack
    assign data_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign addr_arr[i] = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign accept    = !write_valid || write_ready;
  assign transfer  = accept && grant_found;
  assign contended = |(src_valid & (src_valid - NUM_SRC'(1)));

  // Grant is forced low during reset so no source sees an accept that is not taken
  assign src_ready = (rst_n && transfer) ? (NUM_SRC'(1) << grant_idx) : '0;

  if (ARB_MODE == 0) begin : g_fixed
    always_comb begin
      grant_idx   = '0;
      grant_found = |src_valid;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
        if (src_valid[i]) grant_idx = SRC_W'(i);
      end
    end
  end else begin : g_rr
    logic [SRC_W-1:0] ptr;
    logic [SRC_W:0]   probe;

    // Search from ptr upward, wrapping modulo NUM_SRC
    always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      probe       = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
        probe = {1'b0, ptr} + (SRC_W+1)'(k);
        if (probe >= (SRC_W+1)'(NUM_SRC)) probe = probe - (SRC_W+1)'(NUM_SRC);
        if (!grant_found && src_valid[probe[SRC_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = probe[SRC_W-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr <= '0;
      end else if (transfer) begin
        ptr <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
    end
  end

  // Write port register: refill on transfer, drain on consume, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_valid <= 1'b0;
      write_data  <= '0;
      write_addr  <= '0;
      write_src   <= '0;
    end else if (transfer) begin
      write_valid <= 1'b1;
      write_data  <= data_arr[grant_idx];
      write_addr  <= addr_arr[grant_idx];
      write_src   <= grant_idx;
    end else if (write_ready) begin
      write_valid <= 1'b0;
    end
  end

  // Saturating contention counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_count <= '0;
    end else if (clear_count) begin
      conflict_count <= '0;
    end else if (accept && contended && conflict_count != '1) begin
      conflict_count <= conflict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/wb_select_arb.md
Name: wb_select_arb

Overview:
- Parametrised successor to the datapath's 2:1 write-back select.
- Takes NUM_SRC producers (ALU, load unit, etc.), each with a valid/ready handshake, and arbitrates among them.
- Registers the winning data/address into a single write port toward the register file.
- Adds a back-pressure handshake on the write side and a saturating conflict counter for performance visibility.

Parameters:
- DATA_WIDTH, 4, width of each source datum and write_data.
- ADDR_WIDTH, 3, destination register address width.
- NUM_SRC, 4, number of source channels; legal range 2..16.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.
- CNT_WIDTH, 8, conflict counter width.
- Localparam SRC_W = clog2(NUM_SRC).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- src_valid  input  NUM_SRC  per-source request.
- src_data  input  NUM_SRC*DATA_WIDTH  flattened; source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_addr  input  NUM_SRC*ADDR_WIDTH  flattened; source i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- src_ready  output  NUM_SRC  one-hot (or zero) grant/accept.
- write_valid  output  1  write port holds a valid entry.
- write_ready  input  1  downstream consumes the entry this cycle.
- write_data  output  DATA_WIDTH  registered selected datum.
- write_addr  output  ADDR_WIDTH  registered selected address.
- write_src  output  SRC_W  index of the source that produced the current entry.
- clear_count  input  1  synchronous clear of conflict_count.
- conflict_count  output  CNT_WIDTH  saturating count of contended accept cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write_valid, write_data, write_addr, write_src = 0.
  - Round-robin pointer = 0; conflict_count = 0.
  - src_ready = 0 while in reset.
- accept = !write_valid | write_ready (combinational).
- Grant (combinational):
  - When accept and any src_valid is high, select exactly one requesting source g.
  - src_ready[g] = 1; all other src_ready = 0.
  - When accept = 0 or no valid, src_ready = 0.
  - src_ready depends on src_valid. Sources must hold valid/data/addr stable until ready; dropping valid early is illegal.
- Arbitration:
  - ARB_MODE 0: lowest set index of src_valid wins.
  - ARB_MODE 1: search starts at ptr, wrapping modulo NUM_SRC. On a transfer, ptr <= (g+1) mod NUM_SRC; g = NUM_SRC-1 wraps ptr to 0. ptr is unchanged on cycles without a transfer.
- Transfer = src_valid[g] & src_ready[g]. On a transfer, next edge loads:
  - write_data <= data of g; write_addr <= addr of g; write_src <= g; write_valid <= 1.
- Latency and throughput:
  - One cycle from transfer to write_valid.
  - Sustained one entry per cycle when write_ready is held high.
- Drain without refill: if write_ready is high and there is no transfer, write_valid <= 0; data/addr/src hold their last values.
- Stall: if write_valid = 1 and write_ready = 0, all outputs hold, src_ready = 0, ptr holds.
- Simultaneous drain and refill (write_valid = 1, write_ready = 1, transfer): the new entry replaces the old one, write_valid stays 1, no bubble.
- conflict_count:
  - Increments on edges where accept = 1 and popcount(src_valid) >= 2.
  - Saturates at 2^CNT_WIDTH-1 (no wrap).
  - clear_count has priority over increment; the count is 0 on the next edge.
- Reset mid-operation: an in-flight entry is discarded (write_valid drops immediately) and ptr returns to 0.
- Parameter checks: NUM_SRC < 2 or ARB_MODE outside {0,1} is rejected at elaboration via a generate-time error.

Test Plan:
- Reset release, no valids, write_ready = 1 -> write_valid = 0, src_ready = 0, conflict_count = 0 for 10 cycles.
- Fixed priority (ARB_MODE 0), src_valid = 4'b1010, src1 data 0x5/addr 3, src3 data 0xC/addr 6, write_ready = 1:
  - Edge 1: write_data = 0x5, write_addr = 3, write_src = 1.
  - Src1 deasserts; next edge: write_data = 0xC, write_src = 3.
  - conflict_count = 1.
- Round robin (ARB_MODE 1), all four valid continuously, write_ready = 1 -> write_src sequence 0,1,2,3,0,1; one entry per cycle, no bubbles.
- Back-pressure: entry 0x9 loaded, write_ready = 0 for 3 cycles with src2 valid -> outputs hold 0x9, src_ready = 0. write_ready = 1 -> src2 entry loads the same edge, write_valid stays 1.
- Saturation, CNT_WIDTH = 3, two sources valid for 12 accept cycles -> conflict_count stops at 7. Pulse clear_count during contention -> count = 0 on the next edge.
- Async reset asserted mid-stream, between clock edges, with write_valid = 1 and ptr = 2 -> write_valid = 0 immediately. After release with all valid, first grant = source 0.
